// File: rtl/seg7_hex_display.sv
// Registered multi-digit hex-to-7-segment driver with leading-zero
// suppression, per-digit blinking, global enable and a blank-until-loaded guard.
module seg7_hex_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      enable,
  output logic [7*NUM_DIGITS-1:0]   seg,
  output logic                      shown
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned SW = 7 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  // XOR mask that both inverts glyphs and doubles as the "all off" pattern
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [VW-1:0] val_q;
  logic          shown_q;
  logic [CW-1:0] cnt_q;
  logic          hidden_q;
  logic [SW-1:0] seg_q;
  logic [SW-1:0] seg_d;
  logic [3:0]    nib;
  logic [6:0]    dig;
  logic          zero_run;

  // Active-high glyph in gfedcba order
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

  // Next display image; zero_run tracks "all nibbles from the top down to here are zero"
  always_comb begin
    seg_d    = {NUM_DIGITS{SEG_OFF}};
    nib      = 4'h0;
    dig      = SEG_OFF;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib      = val_q[4*i +: 4];
      zero_run = zero_run && (nib == 4'h0);
      if (!shown_q || !enable)
        dig = SEG_OFF;
      else if (blank_lz && zero_run && (i != 0))
        dig = SEG_OFF;
      else if (hidden_q && blink_mask[i])
        dig = SEG_OFF;
      else
        dig = glyph(nib) ^ SEG_OFF;
      seg_d[7*i +: 7] = dig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      shown_q  <= 1'b0;
      cnt_q    <= '0;
      hidden_q <= 1'b0;
      seg_q    <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      seg_q <= seg_d;
      if (load) begin
        // a load always restarts the blink period in the visible phase
        val_q    <= value;
        shown_q  <= 1'b1;
        cnt_q    <= '0;
        hidden_q <= 1'b0;
      end else if (shown_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q    <= '0;
          hidden_q <= ~hidden_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign seg   = seg_q;
  assign shown = shown_q;

endmodule

// File: doc/seg7_hex_display.md
Name: seg7_hex_display

Overview:
- Parametrised, registered multi-digit driver for the DE1-SoC HEX displays.
- Latches a packed hex word on a load strobe and decodes each nibble to active-low or active-high 7-segment patterns.
- Adds leading-zero suppression, per-digit blinking from an internal prescaler, a global display enable, and a blank-until-first-load guard.
- Sits between datapath logic (e.g. search results, counters) and the HEX0..HEX(N-1) pins.

Parameters:
- NUM_DIGITS, 6: number of digits; digit 0 is least significant. Legal range 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period; must be >= 2.
- ACTIVE_LOW, 1: 1 = segment on is 0 (DE1-SoC); 0 = segment on is 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- load, input, 1: capture value when high at a rising edge.
- value, input, 4*NUM_DIGITS: packed nibbles; nibble i is [4i+3:4i] for digit i.
- blank_lz, input, 1: 1 = suppress leading zeros.
- blink_mask, input, NUM_DIGITS: bit i = 1 makes digit i blink.
- enable, input, 1: 0 = blank all digits.
- seg, output, 7*NUM_DIGITS: digit i pattern on [7i+6:7i], bit order gfedcba.
- shown, output, 1: 1 when a value has been loaded since reset.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-operation):
  - value register = 0, shown = 0.
  - Blink counter = 0, blink phase = visible.
  - seg = all segments off (all 1s if ACTIVE_LOW, all 0s otherwise).
- Capture: load high at edge N → value register and shown = 1 update at edge N; seg reflects the new value after edge N+1. Load-to-display latency is 2 edges. Load held high recaptures every cycle.
- Output register: seg is fully registered with no combinational path from inputs to seg. blank_lz, blink_mask and enable affect seg 1 cycle after they are sampled.
- Glyphs (gfedcba, active-high form; invert when ACTIVE_LOW = 1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - All 16 codes display a glyph; F is the F glyph, not blank.
- Leading-zero suppression (blank_lz = 1):
  - Scan from digit NUM_DIGITS-1 downward; each digit whose nibble is 0 is blanked until the first nonzero nibble.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Embedded zeros are displayed.
- Blink:
  - Counter runs 0..BLINK_DIV-1 whenever shown = 1. At the terminal count it wraps to 0 and the phase toggles.
  - In the hidden phase, digits with blink_mask bit = 1 are blank; in the visible phase they display normally.
  - A load restarts blinking: counter = 0, phase = visible. If load coincides with the terminal count, the load wins.
  - Counter width is $clog2(BLINK_DIV).
- Blanking priority, highest first: shown = 0, then enable = 0, then leading-zero suppression, then blink-hidden. Otherwise the glyph is shown.
- Blank means all segments off for the configured polarity.
- Width rules: value is sliced by digit index only; no arithmetic on the data path.

Test Plan:
- Reset, then no load for 10 cycles → seg = all 1s (ACTIVE_LOW = 1), shown = 0.
- NUM_DIGITS = 6, load value 24'h12AF05, blank_lz = 0, enable = 1 → after 2 edges, digits 5..0 = 1,2,A,F,0,5. Check digit 2 = 0001110 (F) and digit 1 = 1000000 (0).
- Load 24'h000305, blank_lz = 1 → digits 5..3 blank, digits 2..0 show 3,0,5. Then load 24'h000000 → only digit 0 shows "0" (1000000).
- BLINK_DIV = 4, blink_mask = 6'b000001, value 24'h000007 → digit 0 alternates 1111000 and 1111111 every 4 cycles; other digits steady.
- Pulse load on the cycle the blink counter reaches 3 (hidden → visible boundary) → counter = 0 and phase = visible, so digit 0 stays visible for the next 4 cycles.
- Mid-display, assert rst_n low asynchronously between edges → seg goes all 1s immediately and shown = 0. After release, the display stays blank until the next load.
